// File: rtl/stall_ctrl_pkg.sv
// Shared types, encodings and stall-vector helper for the pipeline sequencer.
package stall_ctrl_pkg;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned INST_ADDR_W = 32;

    typedef logic [STALL_W-1:0]     stall_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Bit i = 1 holds stage i: [0]PC [1]ID [2]EX [3]MEM [4]WB [5]unused
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IF   = 6'b000001;
    localparam stall_t STALL_ID   = 6'b000011;
    localparam stall_t STALL_MEM  = 6'b001111;

    // MEM > ID > IF; an issued flush discards the younger-stage requests.
    function automatic stall_t stall_vec(input logic mem_req, input logic id_req,
                                         input logic if_req, input logic flush);
        stall_t v;
        v = STALL_NONE;
        if (mem_req) begin
            v = STALL_MEM;
        end else if (!flush) begin
            if (id_req) begin
                v = STALL_ID;
            end else if (if_req) begin
                v = STALL_IF;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous reset and global enable.
module stall_ctrl_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] q_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rdy_i && inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline sequencer: merges stage stall requests, issues (or defers) branch flushes,
// and keeps stall/flush statistics plus a memory-hang watchdog.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   if_stall_req,
    input  logic                   id_stall_req,
    input  logic                   mem_stall_req,
    input  logic                   ex_b_flag,
    input  logic [INST_ADDR_W-1:0] ex_b_target,
    output logic [STALL_W-1:0]     stall_state,
    output logic                   b_flag_o,
    output logic [INST_ADDR_W-1:0] b_target_o,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic                   hang_o
);

    localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

    state_e     state_q, state_d;
    inst_addr_t tgt_q, tgt_d;
    logic       b_flag_c;
    inst_addr_t b_target_c;
    stall_t     stall_c;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            hang_q, hang_d;

    // Redirect FSM: a mispredict resolved under a MEM stall is parked until MEM releases.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        b_flag_c   = 1'b0;
        b_target_c = '0;
        if (!rst && rdy) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_b_flag) begin
                        if (mem_stall_req) begin
                            tgt_d   = ex_b_target;
                            state_d = ST_HOLD;
                        end else begin
                            b_flag_c   = 1'b1;
                            b_target_c = ex_b_target;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!mem_stall_req) begin
                        b_flag_c   = 1'b1;
                        b_target_c = tgt_q;
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        stall_c = rst ? STALL_NONE
                      : stall_vec(mem_stall_req, id_stall_req, if_stall_req, b_flag_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Watchdog counts consecutive enabled MEM-stall cycles; the hang flag is sticky.
    always_comb begin
        wd_d   = wd_q;
        hang_d = hang_q;
        if (rdy) begin
            if (mem_stall_req) begin
                if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end else begin
                wd_d = '0;
            end
            if (wd_d == WD_MAX) begin
                hang_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q   <= '0;
            hang_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            hang_q <= hang_d;
        end
    end

    stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .rdy_i (rdy),
        .inc_i (stall_c != STALL_NONE),
        .q_o   (stall_cnt)
    );

    stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .rdy_i (rdy),
        .inc_i (b_flag_c),
        .q_o   (flush_cnt)
    );

    // EX is frozen while a redirect is parked, so it cannot resolve another one.
    a_no_flag_in_hold: assert property (@(posedge clk) disable iff (rst)
        (rdy && state_q == ST_HOLD) |-> !ex_b_flag);

    assign stall_state = stall_c;
    assign b_flag_o    = b_flag_c;
    assign b_target_o  = b_target_c;
    assign hang_o      = hang_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: vector table plus multi-cycle flush, reset and watchdog sequences.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy, ifr, idr, memr, bf;
    logic [31:0] tgt;
    logic [5:0]  stall_state;
    logic        b_flag_o, hang_o;
    logic [31:0] b_target_o, stall_cnt, flush_cnt;

    // Second instance with tiny limits to reach counter saturation and the watchdog quickly
    logic        s_idr, s_memr, s_bf;
    logic [5:0]  s_stall;
    logic        s_bflag, s_hang;
    logic [31:0] s_btgt;
    logic [2:0]  s_scnt, s_fcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_stall_req(ifr), .id_stall_req(idr), .mem_stall_req(memr),
        .ex_b_flag(bf), .ex_b_target(tgt),
        .stall_state(stall_state), .b_flag_o(b_flag_o), .b_target_o(b_target_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hang_o(hang_o)
    );

    stall_ctrl #(.WDOG_LIMIT(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .rdy(1'b1),
        .if_stall_req(1'b0), .id_stall_req(s_idr), .mem_stall_req(s_memr),
        .ex_b_flag(s_bf), .ex_b_target(32'h0000_0040),
        .stall_state(s_stall), .b_flag_o(s_bflag), .b_target_o(s_btgt),
        .stall_cnt(s_scnt), .flush_cnt(s_fcnt), .hang_o(s_hang)
    );

    typedef struct {
        logic        rdy, ifr, idr, memr, bf;
        logic [31:0] tgt;
        logic [5:0]  e_stall;
        logic        e_bf;
        logic [31:0] e_tgt, e_scnt, e_fcnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic d, input logic m,
                         input logic b, input logic [31:0] t);
        rdy = r; ifr = f; idr = d; memr = m; bf = b; tgt = t;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_idr = 1'b0; s_memr = 1'b0; s_bf = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0AAA);
        tick();
        // Reset cycle with live requests: combinational outputs forced quiet
        chk("rst_stall", 32'(stall_state), 32'h0);
        chk("rst_bflag", 32'(b_flag_o), 32'h0);
        chk("rst_btgt", b_target_o, 32'h0);
        tick();
        chk("rst_scnt", stall_cnt, 32'h0);
        chk("rst_fcnt", flush_cnt, 32'h0);
        chk("rst_hang", 32'(hang_o), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("idle_stall", 32'(stall_state), 32'h0);
            chk("idle_bflag", 32'(b_flag_o), 32'h0);
            tick();
        end
        chk("idle_scnt", stall_cnt, 32'h0);

        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   6'h03, 1'b0, 32'h0,   32'd0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   6'h00, 1'b0, 32'h0,   32'd1, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   6'h01, 1'b0, 32'h0,   32'd1, 32'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   6'h0F, 1'b0, 32'h0,   32'd2, 32'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 6'h00, 1'b1, 32'h100, 32'd3, 32'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   6'h00, 1'b0, 32'h0,   32'd3, 32'd1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 6'h00, 1'b1, 32'h200, 32'd3, 32'd1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 6'h00, 1'b1, 32'h300, 32'd3, 32'd2};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 6'h00, 1'b0, 32'h0,   32'd3, 32'd3};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   6'h00, 1'b0, 32'h0,   32'd3, 32'd3};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rdy, vecs[i].ifr, vecs[i].idr, vecs[i].memr, vecs[i].bf, vecs[i].tgt);
            chk($sformatf("vec%0d_stall", i), 32'(stall_state), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_bflag", i), 32'(b_flag_o), 32'(vecs[i].e_bf));
            chk($sformatf("vec%0d_btgt", i), b_target_o, vecs[i].e_tgt);
            chk($sformatf("vec%0d_scnt", i), stall_cnt, vecs[i].e_scnt);
            chk($sformatf("vec%0d_fcnt", i), flush_cnt, vecs[i].e_fcnt);
            tick();
        end

        // Mispredict under a MEM stall: parked, then issued exactly once on release
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_002C);
        chk("defer_bflag0", 32'(b_flag_o), 32'h0);
        chk("defer_btgt0", b_target_o, 32'h0);
        chk("defer_stall0", 32'(stall_state), 32'h0F);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("defer_hold_bflag", 32'(b_flag_o), 32'h0);
            chk("defer_hold_stall", 32'(stall_state), 32'h0F);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("defer_rel_bflag", 32'(b_flag_o), 32'h1);
        chk("defer_rel_btgt", b_target_o, 32'h0000_002C);
        chk("defer_rel_stall", 32'(stall_state), 32'h0);
        chk("defer_rel_fcnt", flush_cnt, 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("defer_after_bflag", 32'(b_flag_o), 32'h0);
            tick();
        end
        chk("defer_fcnt", flush_cnt, 32'd4);

        // Parked redirect waits out a rdy=0 window even though MEM has released
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("frz_bflag", 32'(b_flag_o), 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("frz_rel_bflag", 32'(b_flag_o), 32'h1);
        chk("frz_rel_btgt", b_target_o, 32'h0000_0055);
        tick();
        chk("frz_fcnt", flush_cnt, 32'd5);

        // Reset while a redirect is parked drops it
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0077);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rsthold_bflag", 32'(b_flag_o), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("rsthold_after_bflag", 32'(b_flag_o), 32'h0);
            tick();
        end
        chk("rsthold_fcnt", flush_cnt, 32'd0);

        // Watchdog: 1024 enabled MEM-stall cycles with a 5-cycle freeze in the middle
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        chk("wd_scnt_500", stall_cnt, 32'd500);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        chk("wd_frz_scnt", stall_cnt, 32'd500);
        chk("wd_frz_hang", 32'(hang_o), 32'h0);
        for (int i = 0; i < 523; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        chk("wd_1023_hang", 32'(hang_o), 32'h0);
        chk("wd_1023_scnt", stall_cnt, 32'd1023);
        tick();
        chk("wd_1024_hang", 32'(hang_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        chk("wd_sticky_hang", 32'(hang_o), 32'h1);

        // Small instance: saturation and watchdog clear-on-drop
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        s_idr = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_scnt", 32'(s_scnt), 32'd7);
        s_idr = 1'b0; s_bf = 1'b1;
        #1;
        chk("sat_bflag", 32'(s_bflag), 32'h1);
        chk("sat_btgt", s_btgt, 32'h0000_0040);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_fcnt", 32'(s_fcnt), 32'd7);
        s_bf = 1'b0; s_memr = 1'b1;
        #1;
        chk("sat_mem_stall", 32'(s_stall), 32'h0F);
        for (int i = 0; i < 3; i++) tick();
        s_memr = 1'b0;
        tick();
        s_memr = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("swd_3_hang", 32'(s_hang), 32'h0);
        tick();
        chk("swd_4_hang", 32'(s_hang), 32'h1);
        s_memr = 1'b0;
        tick();
        tick();
        chk("swd_sticky", 32'(s_hang), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
